// File: rtl/scanner_receiver.sv
// rtl/scanner_receiver.sv - serial word deserializer feeding a small FIFO, with scanner ready handshake
// Optional partial-word abort on serial-clock inactivity: define SCANNER_RECEIVER_TIMEOUT_EN.
module scanner_receiver #(
  parameter int WORD_BITS = 4,
  parameter int DEPTH     = 4,
  parameter int PTR_BITS  = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serialClk,
  input  logic                  serialData,
  output logic                  readyForTransfer,
  input  logic                  rdEn,
  output logic [WORD_BITS-1:0]  rdData,
  output logic                  fifoEmpty,
  output logic                  fifoFull,
  output logic [PTR_BITS:0]     fifoCount,
  output logic                  overflowErr,
  output logic                  timeoutErr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam int CNT_BITS = $clog2(WORD_BITS + 1);
  localparam logic [CNT_BITS-1:0] LAST_BIT  = CNT_BITS'(WORD_BITS - 1);
  localparam logic [PTR_BITS:0]   FULL_CNT  = (PTR_BITS + 1)'(DEPTH);

  logic                 sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic                 sdata_s1_q, sdata_s1_d, sdata_s2_q, sdata_s2_d;
  logic [1:0]           state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [CNT_BITS-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]    count_q, count_d;
  logic                 empty_q, empty_d, full_q, full_d;
  logic [WORD_BITS-1:0] rd_data_q, rd_data_d;
  logic [WORD_BITS-1:0] mem_q [DEPTH];
  logic [WORD_BITS-1:0] mem_d [DEPTH];
  logic                 ovf_q, ovf_d, tmo_q, tmo_d;
  logic                 sclk_rise, wr_en, rd_en;
  logic [WORD_BITS:0]   shift_ext;

`ifdef SCANNER_RECEIVER_TIMEOUT_EN
  localparam int IDLE_BITS = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_BITS-1:0] IDLE_LAST = IDLE_BITS'(TIMEOUT - 1);
  logic [IDLE_BITS-1:0] idle_cnt_q, idle_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign shift_ext = {shift_q, sdata_s2_q};
  assign rd_en     = rdEn & ~empty_q;

  always_comb begin
    sclk_s1_d   = serialClk;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    sdata_s1_d  = serialData;
    sdata_s2_d  = sdata_s1_q;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    wr_en       = 1'b0;
`ifdef SCANNER_RECEIVER_TIMEOUT_EN
    idle_cnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (sclk_rise) begin
          if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            shift_d   = shift_ext[WORD_BITS-1:0];
            bit_cnt_d = CNT_BITS'(1);
            state_d   = (WORD_BITS == 1) ? COMMIT : SHIFT;
          end
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d   = shift_ext[WORD_BITS-1:0];
          bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
          if (bit_cnt_q == LAST_BIT) state_d = COMMIT;
        end
`ifdef SCANNER_RECEIVER_TIMEOUT_EN
        else if (idle_cnt_q == IDLE_LAST) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_BITS'(1);
        end
`endif
      end
      COMMIT: begin
        wr_en     = 1'b1;
        bit_cnt_d = '0;
        state_d   = IDLE;
        if (sclk_rise) ovf_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry to a word requires a free slot, so a COMMIT write never meets a full FIFO.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
    end
    if (rd_en) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_BITS'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PTR_BITS + 1)'(1);
      2'b01:   count_d = count_q - (PTR_BITS + 1)'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sdata_s1_q  <= 1'b0;
      sdata_s2_q  <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rd_data_q   <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      sdata_s1_q  <= sdata_s1_d;
      sdata_s2_q  <= sdata_s2_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      rd_data_q   <= rd_data_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
    end
  end

`ifdef SCANNER_RECEIVER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`endif

  assign readyForTransfer = ~rst & (state_q == IDLE) & ~full_q;
  assign rdData           = rd_data_q;
  assign fifoEmpty        = empty_q;
  assign fifoFull         = full_q;
  assign fifoCount        = count_q;
  assign overflowErr      = ovf_q;
  assign timeoutErr       = tmo_q;

endmodule

// File: tb/tb_scanner_receiver.sv
// tb/tb_scanner_receiver.sv - directed self-checking bench for scanner_receiver
module tb_scanner_receiver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serialClk = 1'b0;
  logic       serialData = 1'b0;
  logic       readyForTransfer;
  logic       rdEn = 1'b0;
  logic [3:0] rdData;
  logic       fifoEmpty;
  logic       fifoFull;
  logic [2:0] fifoCount;
  logic       overflowErr;
  logic       timeoutErr;
  int         total = 0;
  int         bad = 0;

  scanner_receiver dut (
    .clk(clk), .rst(rst), .serialClk(serialClk), .serialData(serialData),
    .readyForTransfer(readyForTransfer), .rdEn(rdEn), .rdData(rdData),
    .fifoEmpty(fifoEmpty), .fifoFull(fifoFull), .fifoCount(fifoCount),
    .overflowErr(overflowErr), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One serial bit: 4 clk low with data set up, 4 clk high.
  task automatic send_bit(input logic b);
    serialData = b;
    tick(4);
    serialClk = 1'b1;
    tick(4);
    serialClk = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    tick(2);
  endtask

  task automatic pop();
    rdEn = 1'b1;
    tick(1);
    rdEn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    total++; if (readyForTransfer !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", readyForTransfer); end
    total++; if ({rdData, fifoEmpty, fifoFull, fifoCount, overflowErr, timeoutErr} !== {4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0})
      begin bad++; $display("FAIL reset_outputs got=%b%b%b%b%b%b", rdData, fifoEmpty, fifoFull, fifoCount, overflowErr, timeoutErr); end
    rst = 1'b0;
    tick(1);
    total++; if (readyForTransfer !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", readyForTransfer); end
  endtask

  task automatic test_single_word();
    send_bit(1'b0);
    total++; if (readyForTransfer !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b exp=0", readyForTransfer); end
    send_bit(1'b1);
    send_bit(1'b0);
    serialData = 1'b1;
    tick(4);
    serialClk = 1'b1;
    tick(3);
    total++; if (fifoCount !== 3'd0) begin bad++; $display("FAIL commit_early got=%0d exp=0", fifoCount); end
    tick(1);
    total++; if (fifoCount !== 3'd1) begin bad++; $display("FAIL commit_count got=%0d exp=1", fifoCount); end
    total++; if (fifoEmpty !== 1'b0) begin bad++; $display("FAIL commit_empty got=%b exp=0", fifoEmpty); end
    serialClk = 1'b0;
    tick(2);
    pop();
    total++; if (rdData !== 4'b0101) begin bad++; $display("FAIL single_data got=%b exp=0101", rdData); end
    total++; if (fifoCount !== 3'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", fifoCount); end
  endtask

  task automatic test_fill_overflow();
    logic [3:0] exp_words [4];
    exp_words[0] = 4'b1001; exp_words[1] = 4'b1110; exp_words[2] = 4'b0011; exp_words[3] = 4'b1111;
    for (int i = 0; i < 4; i++) send_word(exp_words[i]);
    total++; if ({fifoFull, fifoCount, readyForTransfer} !== {1'b1, 3'd4, 1'b0})
      begin bad++; $display("FAIL full_state got full=%b cnt=%0d rdy=%b exp 1 4 0", fifoFull, fifoCount, readyForTransfer); end
    total++; if (overflowErr !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflowErr); end
    send_bit(1'b1);
    tick(2);
    total++; if (overflowErr !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflowErr); end
    total++; if (fifoCount !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", fifoCount); end
    for (int i = 0; i < 4; i++) begin
      pop();
      total++; if (rdData !== exp_words[i]) begin bad++; $display("FAIL fill_pop%0d got=%b exp=%b", i, rdData, exp_words[i]); end
    end
    total++; if ({fifoEmpty, readyForTransfer} !== 2'b11) begin bad++; $display("FAIL drained got=%b%b exp=11", fifoEmpty, readyForTransfer); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_words [4];
    exp_words[0] = 4'b0010; exp_words[1] = 4'b0100; exp_words[2] = 4'b0110; exp_words[3] = 4'b1000;
    for (int i = 0; i < 3; i++) send_word(exp_words[i]);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    serialData = 1'b0;
    tick(4);
    serialClk = 1'b1;
    tick(3);
    rdEn = 1'b1;
    tick(1);
    rdEn = 1'b0;
    total++; if ({fifoCount, fifoFull} !== {3'd3, 1'b0}) begin bad++; $display("FAIL simul_count got=%0d full=%b exp 3 0", fifoCount, fifoFull); end
    total++; if (rdData !== exp_words[0]) begin bad++; $display("FAIL simul_pop got=%b exp=%b", rdData, exp_words[0]); end
    serialClk = 1'b0;
    tick(2);
    for (int i = 1; i < 4; i++) begin
      pop();
      total++; if (rdData !== exp_words[i]) begin bad++; $display("FAIL wrap_pop%0d got=%b exp=%b", i, rdData, exp_words[i]); end
    end
    total++; if (fifoEmpty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", fifoEmpty); end
  endtask

  task automatic test_reset_midword();
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    tick(1);
    total++; if ({rdData, fifoEmpty, fifoFull, fifoCount, overflowErr, timeoutErr, readyForTransfer} !== {4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0})
      begin bad++; $display("FAIL midreset_outputs got rd=%b e=%b f=%b c=%0d o=%b t=%b r=%b", rdData, fifoEmpty, fifoFull, fifoCount, overflowErr, timeoutErr, readyForTransfer); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_rd_empty();
    rdEn = 1'b1;
    tick(3);
    rdEn = 1'b0;
    total++; if ({rdData, fifoCount, fifoEmpty} !== {4'b0000, 3'd0, 1'b1})
      begin bad++; $display("FAIL rd_empty got rd=%b c=%0d e=%b exp 0000 0 1", rdData, fifoCount, fifoEmpty); end
  endtask

  task automatic test_fresh_word();
    send_word(4'b1100);
    total++; if (fifoCount !== 3'd1) begin bad++; $display("FAIL fresh_count got=%0d exp=1", fifoCount); end
    pop();
    total++; if (rdData !== 4'b1100) begin bad++; $display("FAIL fresh_data got=%b exp=1100", rdData); end
  endtask

  task automatic test_timeout();
    send_bit(1'b1);
    send_bit(1'b0);
    tick(70);
`ifdef SCANNER_RECEIVER_TIMEOUT_EN
    total++; if ({timeoutErr, fifoCount, readyForTransfer} !== {1'b1, 3'd0, 1'b1})
      begin bad++; $display("FAIL timeout_abort got t=%b c=%0d r=%b exp 1 0 1", timeoutErr, fifoCount, readyForTransfer); end
    send_word(4'b0110);
    pop();
    total++; if (rdData !== 4'b0110) begin bad++; $display("FAIL timeout_recover got=%b exp=0110", rdData); end
`else
    total++; if ({timeoutErr, readyForTransfer} !== 2'b00)
      begin bad++; $display("FAIL no_timeout got t=%b r=%b exp 0 0", timeoutErr, readyForTransfer); end
    send_bit(1'b1);
    send_bit(1'b0);
    tick(2);
    total++; if (fifoCount !== 3'd1) begin bad++; $display("FAIL late_count got=%0d exp=1", fifoCount); end
    pop();
    total++; if (rdData !== 4'b1010) begin bad++; $display("FAIL late_data got=%b exp=1010", rdData); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_simultaneous();
    test_reset_midword();
    test_rd_empty();
    test_fresh_word();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
